// File: rtl/issue_sched_pkg.sv
// Shared types for the dual-issue scheduler: opcodes, FSM states, decoded class.
// Latency: n/a (types and a pure combinational hazard function).
// Backpressure: n/a.
package issue_sched_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BUBBLE = 7'b0000000;

  typedef enum logic [0:0] {
    PAIR   = 1'b0,
    SECOND = 1'b1
  } state_e;

  typedef struct packed {
    logic       writes_rd;
    logic       reads_rs1;
    logic       reads_rs2;
    logic       is_ctrl;
    logic       is_io;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } instr_class_t;

  // True when the younger instruction (s1) may not issue alongside the older (s0).
  function automatic logic pair_conflict(instr_class_t s0, instr_class_t s1);
    logic raw;
    logic waw;
    raw = s0.writes_rd && ((s1.reads_rs1 && (s1.rs1 == s0.rd)) ||
                           (s1.reads_rs2 && (s1.rs2 == s0.rd)));
    waw = s0.writes_rd && s1.writes_rd && (s0.rd == s1.rd);
    return raw || waw || s0.is_ctrl || s1.is_ctrl || (s0.is_io && s1.is_io);
  endfunction

endpackage

// File: rtl/issue_scheduler_classify.sv
// Decodes one 32-bit instruction into its hazard-relevant class.
// Latency: purely combinational.
// Backpressure: none.
module instr_classify
  import issue_sched_pkg::*;
(
  input  logic [31:0]  instr_i,
  output instr_class_t cls_o
);

  logic [6:0] opcode;
  logic       unused_fields;

  assign opcode        = instr_i[6:0];
  assign unused_fields = ^{instr_i[31:25], instr_i[14:12]};

  // Opcode-driven class flags; a bubble (all-zero opcode) matches nothing.
  always_comb begin
    cls_o           = '0;
    cls_o.rd        = instr_i[11:7];
    cls_o.rs1       = instr_i[19:15];
    cls_o.rs2       = instr_i[24:20];
    cls_o.writes_rd = (opcode inside {OP_OP, OP_IMM, OP_LUI, OP_JAL, OP_JALR, OP_SYSTEM}) &&
                      (instr_i[11:7] != 5'd0);
    cls_o.reads_rs1 = opcode inside {OP_OP, OP_IMM, OP_BRANCH, OP_JALR, OP_SYSTEM};
    cls_o.reads_rs2 = opcode inside {OP_OP, OP_BRANCH};
    cls_o.is_ctrl   = opcode inside {OP_BRANCH, OP_JAL, OP_JALR};
    cls_o.is_io     = (opcode == OP_SYSTEM);
  end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: issues a fetched pair together, or splits it over two cycles on hazard.
// Latency: issue outputs registered, one cycle after the decision; pair_ready is combinational.
// Backpressure: pair_ready low holds fetch during the first half of a split. ISSUE_SCHED_PERF_EN adds counters.
module issue_scheduler
  import issue_sched_pkg::*;
#(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pair_valid,
  input  logic [63:0]      pair_instr,
  input  logic [PC_W-1:0]  pair_pc,
  output logic             pair_ready,
  input  logic             flush,
  output logic             issue_valid_0,
  output logic             issue_valid_1,
  output logic [31:0]      issue_instr_0,
  output logic [31:0]      issue_instr_1,
  output logic [PC_W-1:0]  issue_pc_0,
  output logic [PC_W-1:0]  issue_pc_1,
  output logic [CNT_W-1:0] dual_cnt,
  output logic [CNT_W-1:0] split_cnt
);

  instr_class_t    cls0, cls1;
  logic            conflict;
  logic [31:0]     slot0, slot1;
  logic [PC_W-1:0] pc_inc;
  state_e          state_q, state_d;
  logic            v0_q, v0_d, v1_q, v1_d;
  logic [31:0]     i0_q, i0_d, i1_q, i1_d;
  logic [PC_W-1:0] p0_q, p0_d, p1_q, p1_d;
  logic            dual_inc, split_inc;
  logic            unused_cls;

  assign slot0      = pair_instr[63:32];
  assign slot1      = pair_instr[31:0];
  assign pc_inc     = pair_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign conflict   = pair_conflict(cls0, cls1);
  assign unused_cls = cls0.reads_rs1 ^ cls0.reads_rs2;

  instr_classify u_cls0 (.instr_i(slot0), .cls_o(cls0));
  instr_classify u_cls1 (.instr_i(slot1), .cls_o(cls1));

  // Issue decision, handshake and next state; nothing is accepted while in reset.
  always_comb begin
    state_d    = state_q;
    pair_ready = 1'b0;
    v0_d       = 1'b0;
    v1_d       = 1'b0;
    i0_d       = '0;
    i1_d       = '0;
    p0_d       = '0;
    p1_d       = '0;
    dual_inc   = 1'b0;
    split_inc  = 1'b0;
    if (rst_n) begin
      if (state_q == PAIR) begin
        if (flush) begin
          pair_ready = 1'b1;
        end else if (pair_valid) begin
          if (pair_pc[0]) begin
            // Odd branch target: only slot 1 is architecturally live.
            pair_ready = 1'b1;
            v0_d       = 1'b1;
            i0_d       = slot1;
            p0_d       = pair_pc;
          end else if (!conflict) begin
            pair_ready = 1'b1;
            v0_d       = 1'b1;
            i0_d       = slot0;
            p0_d       = pair_pc;
            v1_d       = 1'b1;
            i1_d       = slot1;
            p1_d       = pc_inc;
            dual_inc   = 1'b1;
          end else begin
            v0_d      = 1'b1;
            i0_d      = slot0;
            p0_d      = pair_pc;
            state_d   = SECOND;
            split_inc = 1'b1;
          end
        end
      end else begin
        // Fetch is still holding the pair; a flush here kills the younger half.
        pair_ready = 1'b1;
        state_d    = PAIR;
        if (!flush) begin
          v0_d = 1'b1;
          i0_d = slot1;
          p0_d = pc_inc;
        end
      end
    end
  end

  // State and registered issue slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PAIR;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      i0_q    <= '0;
      i1_q    <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      i0_q    <= i0_d;
      i1_q    <= i1_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
    end
  end

  assign issue_valid_0 = v0_q;
  assign issue_valid_1 = v1_q;
  assign issue_instr_0 = i0_q;
  assign issue_instr_1 = i1_q;
  assign issue_pc_0    = p0_q;
  assign issue_pc_1    = p1_q;

`ifdef ISSUE_SCHED_PERF_EN
  logic [CNT_W-1:0] dual_q, split_q;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dual_q  <= '0;
      split_q <= '0;
    end else begin
      if (dual_inc && !(&dual_q))
        dual_q <= dual_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (split_inc && !(&split_q))
        split_q <= split_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign dual_cnt  = dual_q;
  assign split_cnt = split_q;
`else
  logic unused_perf;
  assign unused_perf = dual_inc ^ split_inc;
  assign dual_cnt    = '0;
  assign split_cnt   = '0;
`endif

endmodule
